hvac_sequencer: RTL
===================

HVAC_SEQUENCER -- requirements
Module: hvac_sequencer

Interface
REQ-001 Parameter: DEBOUNCE, 3, consecutive equal status samples required to accept a new request.
REQ-002 Parameter: MIN_ON, 60, minimum ticks an actuator stays on before a normal stop.
REQ-003 Parameter: MIN_OFF, 60, minimum ticks in dead time plus off before any actuator may start.
REQ-004 Parameter: DEAD_TIME, 30, ticks with both actuators off after any stop.
REQ-005 Parameter: FAULT_CONFIRM, 3, consecutive status==3 samples that latch a fault.
REQ-006 Port: clk  input  1  system clock; all logic on the rising edge.
REQ-007 Port: reset  input  1  synchronous, active-high reset.
REQ-008 Port: tick  input  1  one-clk sample strobe (nominally 1 Hz); the block samples and times only on tick.
REQ-009 Port: status  input  2  thermostat status (0 idle, 1 heat, 2 cool, 3 error).
REQ-010 Port: enable  input  1  system run permit.
REQ-011 Port: fault_clr  input  1  one-clk request to leave FAULT.
REQ-012 Port: heater_on  output  1  heater drive.
REQ-013 Port: fan_on  output  1  cooling fan drive.
REQ-014 Port: fault  output  1  latched fault indicator.
REQ-015 Port: state  output  3  current state code: OFF=0, HEAT=1, COOL=2, DEAD=3, FAULT=4.

Function
REQ-016 Outputs shall be registered and decoded from state: heater_on only in HEAT, fan_on only in COOL, fault only in FAULT.
REQ-017 heater_on and fan_on shall never be 1 in the same cycle; any HEAT<->COOL change shall pass through DEAD.
REQ-018 Debounce: the request register shall take a new status value only after the same value has been sampled on DEBOUNCE consecutive ticks; a differing sample restarts the run count at 1.
REQ-019 Counters (on_cnt, off_cnt, dead_cnt, err_cnt) shall be 8 bits, advance only on tick, and saturate at 255 without wrapping.
REQ-020 OFF: on tick, if enable, off_cnt>=MIN_OFF and request==1, go to HEAT; if request==2 under the same conditions, go to COOL; otherwise stay in OFF.
REQ-021 HEAT/COOL: on_cnt shall clear on entry; leave for DEAD when the request no longer matches and on_cnt>=MIN_ON.
REQ-022 HEAT/COOL: enable low shall force DEAD on the next tick, regardless of on_cnt.
REQ-023 DEAD: off_cnt and dead_cnt shall clear on entry; go to OFF once dead_cnt>=DEAD_TIME; off_cnt shall keep counting through OFF.
REQ-024 err_cnt shall increment on each tick with raw status==3 and clear on any other sample.
REQ-025 When err_cnt reaches FAULT_CONFIRM, the block shall go to FAULT from any state, on that same tick.
REQ-026 Fault entry shall take priority over every other transition.
REQ-027 FAULT: the block shall go to DEAD on fault_clr only when the last sampled raw status!=3; otherwise fault_clr shall be ignored.
REQ-028 Latency: any state change shall be visible on the outputs one clk after the deciding tick.
REQ-029 A tick coinciding with reset shall be ignored.

Reset
REQ-030 Reset shall force: state=OFF, all outputs 0, request=0, run count 0, on_cnt=0, dead_cnt=0, err_cnt=0.
REQ-031 Reset shall set off_cnt=255 (saturated), so the first start after reset is limited only by debounce.
REQ-032 Reset asserted mid-run shall turn the actuators off on the next clk, without passing through DEAD.

Structure
REQ-033 State encodings and status codes (idle/heat/cool/error) shall live in shared package greenhouse_pkg, which the thermostat logic also uses.
REQ-034 The debounce filter shall be one sub-module, status_debounce, parameterised by DEBOUNCE.

Verification
REQ-035 Reset, then status=1 held with enable=1: heater_on rises 1 clk after the 3rd tick and is the only actuator on.
REQ-036 Status 1 held for 10 ticks, then 0: heater_on holds until on_cnt=60, then DEAD for 30 ticks, then OFF.
REQ-037 In HEAT, status changes to 2: HEAT(>=60 ticks) -> DEAD(30) -> OFF -> COOL; heater_on and fan_on never overlap, checked every clk.
REQ-038 Status pattern 3,3,0,3,3,3: fault=1 only after the 6th tick; fault_clr while status=3 ignored; fault_clr after status=0 -> DEAD.
REQ-039 Status pattern 1,1,2,1,1,1: HEAT entered only on the 6th tick, confirming the debounce restart.
REQ-040 In COOL, enable=0: DEAD on the next tick, before MIN_ON; reset during COOL clears fan_on in 1 clk.

Source files
------------

// File: rtl/greenhouse_pkg.sv
// greenhouse_pkg
//   Shared definitions for the greenhouse climate blocks. It holds the
//   thermostat status codes, the sequencer state encoding (whose numeric
//   values appear on the state output), the common counter width and a
//   saturating increment helper.
package greenhouse_pkg;

  // Width of every timing/error counter in the sequencer.
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Thermostat status codes, as delivered on the 2-bit status bus.
  localparam logic [1:0] STATUS_IDLE  = 2'd0;
  localparam logic [1:0] STATUS_HEAT  = 2'd1;
  localparam logic [1:0] STATUS_COOL  = 2'd2;
  localparam logic [1:0] STATUS_ERROR = 2'd3;

  // Sequencer states. These codes are visible externally on the state port.
  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_HEAT  = 3'd1,
    ST_COOL  = 3'd2,
    ST_DEAD  = 3'd3,
    ST_FAULT = 3'd4
  } hvac_state_t;

  // Increment that sticks at the top value instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == CNT_MAX) ? value : value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/status_debounce.sv
// status_debounce
//   Filters the raw thermostat status so that a new request is accepted only
//   after the same value has been seen on DEBOUNCE consecutive ticks.
//
//   Ports:
//     clk      - system clock, rising edge
//     reset    - synchronous, active-high reset
//     tick     - one-clk sample strobe; status is sampled only on tick
//     status   - raw thermostat status
//     request  - filtered request; during a tick that completes a run it
//                already shows the newly accepted value, so the sequencer
//                can act on it in that same tick
module status_debounce
  import greenhouse_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] status,
  output logic [1:0] request
);

  localparam int RUN_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(DEBOUNCE);

  logic [1:0]       last_sample;
  logic [1:0]       request_q;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_next;
  logic             accept;

  // Length of the run of equal samples including the current one. A zero
  // run count (after reset) means there is no previous sample yet, so the
  // current one always starts a fresh run.
  always_comb begin
    run_next = RUN_W'(1);
    if ((run_cnt != '0) && (status == last_sample)) begin
      run_next = (run_cnt >= RUN_TARGET) ? RUN_TARGET : run_cnt + RUN_W'(1);
    end
  end

  always_comb begin
    accept  = (run_next >= RUN_TARGET);
    request = (tick && accept) ? status : request_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_sample <= STATUS_IDLE;
      run_cnt     <= '0;
      request_q   <= STATUS_IDLE;
    end else if (tick) begin
      last_sample <= status;
      run_cnt     <= run_next;
      request_q   <= request;
    end
  end

endmodule

// File: rtl/hvac_sequencer.sv
// hvac_sequencer
//   Sequences a heater and a cooling fan from a debounced thermostat status.
//   Enforces minimum on time, minimum off time and a dead time with both
//   actuators off between any stop and the next start, and latches a fault
//   after repeated error samples.
//
//   Ports:
//     clk        - system clock, rising edge
//     reset      - synchronous, active-high reset
//     tick       - one-clk sample strobe; sampling and timing happen on tick
//     status     - thermostat status (0 idle, 1 heat, 2 cool, 3 error)
//     enable     - system run permit
//     fault_clr  - one-clk request to leave FAULT
//     heater_on  - heater drive (registered)
//     fan_on     - cooling fan drive (registered)
//     fault      - latched fault indicator (registered)
//     state      - current state code (OFF=0 HEAT=1 COOL=2 DEAD=3 FAULT=4)
module hvac_sequencer
  import greenhouse_pkg::*;
#(
  parameter int DEBOUNCE      = 3,
  parameter int MIN_ON        = 60,
  parameter int MIN_OFF       = 60,
  parameter int DEAD_TIME     = 30,
  parameter int FAULT_CONFIRM = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] status,
  input  logic       enable,
  input  logic       fault_clr,
  output logic       heater_on,
  output logic       fan_on,
  output logic       fault,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] MIN_ON_C        = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] MIN_OFF_C       = CNT_W'(MIN_OFF);
  localparam logic [CNT_W-1:0] DEAD_TIME_C     = CNT_W'(DEAD_TIME);
  localparam logic [CNT_W-1:0] FAULT_CONFIRM_C = CNT_W'(FAULT_CONFIRM);

  hvac_state_t      state_q;
  hvac_state_t      state_next;
  logic [1:0]       request;
  logic [CNT_W-1:0] on_cnt;
  logic [CNT_W-1:0] off_cnt;
  logic [CNT_W-1:0] dead_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] err_next;
  logic             last_err;
  logic             err_fault;
  logic             entering_run;
  logic             entering_dead;

  status_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .status  (status),
    .request (request)
  );

  // Consecutive error samples including the one taken on this tick; the
  // fault decision uses this value so the fault lands on the confirming tick.
  always_comb begin
    err_next  = (status == STATUS_ERROR) ? sat_inc(err_cnt) : '0;
    err_fault = tick && (err_next >= FAULT_CONFIRM_C);
  end

  // Next-state logic. Fault entry outranks everything. Leaving FAULT is the
  // only transition not tied to tick, and it is refused while the most
  // recent raw sample was still an error.
  always_comb begin
    state_next = state_q;
    if (err_fault) begin
      state_next = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      if (fault_clr && !last_err) begin
        state_next = ST_DEAD;
      end
    end else if (tick) begin
      case (state_q)
        ST_OFF: begin
          if (enable && (off_cnt >= MIN_OFF_C)) begin
            if (request == STATUS_HEAT) begin
              state_next = ST_HEAT;
            end else if (request == STATUS_COOL) begin
              state_next = ST_COOL;
            end
          end
        end
        ST_HEAT: begin
          if (!enable || ((request != STATUS_HEAT) && (on_cnt >= MIN_ON_C))) begin
            state_next = ST_DEAD;
          end
        end
        ST_COOL: begin
          if (!enable || ((request != STATUS_COOL) && (on_cnt >= MIN_ON_C))) begin
            state_next = ST_DEAD;
          end
        end
        ST_DEAD: begin
          if (dead_cnt >= DEAD_TIME_C) begin
            state_next = ST_OFF;
          end
        end
        default: begin
          state_next = ST_OFF;
        end
      endcase
    end
  end

  always_comb begin
    entering_run  = (state_next != state_q) &&
                    ((state_next == ST_HEAT) || (state_next == ST_COOL));
    entering_dead = (state_next != state_q) && (state_next == ST_DEAD);
  end

  // Outputs are decoded from the next state and registered with it, so a
  // change decided on a tick appears on the pins one clk later and reset
  // drops the actuators immediately without visiting DEAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_OFF;
      heater_on <= 1'b0;
      fan_on    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_next;
      heater_on <= (state_next == ST_HEAT);
      fan_on    <= (state_next == ST_COOL);
      fault     <= (state_next == ST_FAULT);
    end
  end

  // off_cnt starts saturated so the first start after reset waits only for
  // the debounce. It counts from DEAD entry onward, so it covers both dead
  // time and the following OFF period.
  always_ff @(posedge clk) begin
    if (reset) begin
      on_cnt   <= '0;
      off_cnt  <= CNT_MAX;
      dead_cnt <= '0;
      err_cnt  <= '0;
      last_err <= 1'b0;
    end else begin
      if (entering_run) begin
        on_cnt <= '0;
      end else if (tick) begin
        on_cnt <= sat_inc(on_cnt);
      end

      if (entering_dead) begin
        off_cnt  <= '0;
        dead_cnt <= '0;
      end else if (tick) begin
        off_cnt  <= sat_inc(off_cnt);
        dead_cnt <= sat_inc(dead_cnt);
      end

      if (tick) begin
        err_cnt  <= err_next;
        last_err <= (status == STATUS_ERROR);
      end
    end
  end

  assign state = state_q;

endmodule
